// File: rtl/dot_product_pkg.sv
// dot_product_pkg
//   Shared types and constants for the dot-product engine:
//   FSM state encoding, datapath widths and the active-low
//   7-segment glyphs ({g,f,e,d,c,b,a}, 0 = segment lit).
package dot_product_pkg;

    localparam int ELEM_W = 8;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACC   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/dot_product_engine_hex_to_seg7.sv
// hex_to_seg7
//   Combinational hex nibble to active-low 7-segment decoder
//   (b and d drawn lowercase).
//   Ports:
//     nibble  in   4  hex digit value
//     seg     out  7  active-low segments {g..a}
module hex_to_seg7
    import dot_product_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine
//   Streams NUM_ELEM pairs of unsigned bytes, accumulates their products
//   and shows the last completed 18-bit result on a 4-digit multiplexed
//   7-segment display (low 16 bits) plus two LEDs (top 2 bits).
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a mac_enable rising edge
//   PRIME | accumulator cleared; element 0 is on A/B this cycle
//   ACC   | summing elements 1..NUM_ELEM-1
//   HOLD  | result published; waiting for mac_enable to drop
//
//   Ports:
//     clk           in   1   system clock, rising edge
//     rst           in   1   asynchronous active-low reset
//     A, B          in   8   unsigned vector elements, one pair per cycle
//     mac_enable    in   1   transaction window
//     dot_product   out  18  last completed result
//     result_valid  out  1   one-cycle pulse when dot_product updates
//     busy          out  1   high in PRIME or ACC
//     abort_err     out  1   sticky early-window-end flag
//     seg           out  7   active-low segments of the current digit
//     an            out  4   active-low digit anodes
//     led           out  2   dot_product[17:16]
module dot_product_engine
    import dot_product_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_ELEM    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] A,
    input  logic [ELEM_W-1:0] B,
    input  logic              mac_enable,
    output logic [ACC_W-1:0]  dot_product,
    output logic              result_valid,
    output logic              busy,
    output logic              abort_err,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic [1:0]        led
);

    localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  elem_cnt;
    logic              mac_d;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  sum_next;

    assign prod     = PROD_W'(A) * PROD_W'(B);
    assign sum_next = acc + ACC_W'(prod);
    assign led      = dot_product[ACC_W-1:ACC_W-2];

    // The accumulator is cleared on entry to PRIME, so PRIME and ACC share
    // one datapath: elem_cnt is the index of the element on A/B this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            acc          <= '0;
            elem_cnt     <= '0;
            // Reset high so a mac_enable held across reset release does not
            // look like a fresh rising edge.
            mac_d        <= 1'b1;
            dot_product  <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            abort_err    <= 1'b0;
        end else begin
            mac_d        <= mac_enable;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mac_enable && !mac_d) begin
                        state    <= ST_PRIME;
                        busy     <= 1'b1;
                        acc      <= '0;
                        elem_cnt <= '0;
                    end
                end
                ST_PRIME, ST_ACC: begin
                    if (!mac_enable) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        abort_err <= 1'b1;
                        acc       <= '0;
                    end else if (elem_cnt == LAST_IDX) begin
                        state        <= ST_HOLD;
                        busy         <= 1'b0;
                        acc          <= sum_next;
                        dot_product  <= sum_next;
                        result_valid <= 1'b1;
                        abort_err    <= 1'b0;
                    end else begin
                        state    <= ST_ACC;
                        acc      <= sum_next;
                        elem_cnt <= elem_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!mac_enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [REF_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       nibble;
    logic [6:0]       nib_seg;

    always_comb begin
        nibble = dot_product[3:0];
        case (digit_idx)
            2'd0: nibble = dot_product[3:0];
            2'd1: nibble = dot_product[7:4];
            2'd2: nibble = dot_product[11:8];
            2'd3: nibble = dot_product[15:12];
            default: nibble = dot_product[3:0];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (nib_seg)
    );

    // seg and an are both registered from the same digit_idx, so they
    // always switch together on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 4'b1110;
            seg         <= SEG_0;
        end else begin
            if (refresh_cnt == REF_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            an  <= ~(4'b0001 << digit_idx);
            seg <= nib_seg;
        end
    end

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per display digit slot (1 kHz at 100 MHz).
REQ-002 Parameter NUM_ELEM, default 4, vector elements per transaction.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 A  input  8  unsigned element of vector A, streamed one per cycle.
REQ-006 B  input  8  unsigned element of vector B, paired with A.
REQ-007 mac_enable  input  1  transaction window from the loader; first high cycle is a priming cycle, the following NUM_ELEM cycles carry valid A/B.
REQ-008 dot_product  output  18  last completed unsigned result.
REQ-009 result_valid  output  1  one-cycle pulse when dot_product updates.
REQ-010 busy  output  1  high in PRIME or ACC.
REQ-011 abort_err  output  1  sticky; set when a window ends early.
REQ-012 seg  output  7  active-low segments {g..a} of the current digit.
REQ-013 an  output  4  active-low digit anodes; exactly one low at a time.
REQ-014 led  output  2  dot_product[17:16].

Function
REQ-015 States: IDLE, PRIME, ACC, HOLD.
- IDLE -> PRIME on mac_enable rising edge (high now, low the previous cycle).
- PRIME -> ACC next cycle if mac_enable is high; clear the accumulator and set elem_cnt=0.
- ACC: each cycle with mac_enable high, acc += A*B and elem_cnt++. After element NUM_ELEM-1 is added, go to HOLD.
- HOLD -> IDLE when mac_enable is low.
REQ-016 Element k (k=0..NUM_ELEM-1) is sampled on mac_enable-high cycle k+2 of the window.
REQ-017 Arithmetic is unsigned: 8x8 gives a 16-bit product; the accumulator is 18 bits wide and never overflows for NUM_ELEM=4.
REQ-018 On the cycle after the final element is added, dot_product <= final accumulator value and result_valid pulses. Total latency is 1 cycle after the last sample.
REQ-019 If mac_enable falls in PRIME or ACC: go to IDLE, set abort_err, leave dot_product unchanged, no result_valid.
REQ-020 mac_enable staying high past the window is ignored in HOLD. A new transaction requires mac_enable low for at least one cycle.
REQ-021 abort_err clears only on reset or on a successful result_valid.
REQ-022 The display refresh counter runs free and wraps at REFRESH_DIV-1. On wrap, the digit index advances 0->1->2->3->0.
REQ-023 Digit i shows hex nibble dot_product[4i+3:4i] on an[i]. Glyphs for 0-F follow standard hex 7-segment patterns (b, d lowercase).
REQ-024 seg and an are registered and change in the same cycle. There is no blank overlap.

Reset
REQ-025 While rst=0, all outputs take their reset values immediately, independent of clk:
- state=IDLE, accumulator=0, elem_cnt=0
- dot_product=0, result_valid=0, busy=0, abort_err=0
- refresh counter=0, digit index=0, an=4'b1110, seg=glyph '0' (7'b1000000)
REQ-026 If reset asserts mid-transaction, the partial sum is discarded. After release, the block waits for a fresh mac_enable rising edge.

Structure
REQ-027 Package dot_product_pkg holds the state enum, ELEM_W=8, PROD_W=16, ACC_W=18 and the hex glyph constants.
REQ-028 One sub-module, hex_to_seg7: combinational 4-bit nibble to 7-bit active-low segment pattern, instantiated once on the selected nibble.

Verification
REQ-029 A bytes 01,02,03,04 and B bytes 05,06,07,08 in a 5-cycle window -> dot_product=0x00046 one cycle after the last element; result_valid high for exactly 1 cycle.
REQ-030 All A and B bytes = 0xFF -> dot_product=0x3F804, led=2'b11, digits from an[3] to an[0] show F,8,0,4.
REQ-031 mac_enable drops after 2 elements, with a prior result of 0x46 -> abort_err=1, dot_product stays 0x46, no result_valid; the next full window clears abort_err.
REQ-032 mac_enable held high for 8 cycles -> exactly one result; only elements from cycles 2-5 are summed.
REQ-033 rst asserted during ACC, asynchronously and between clock edges -> outputs at reset values before the next edge; a following full window computes correctly.
REQ-034 REFRESH_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks, with seg matching each nibble.
